// File: rtl/cordic_avg_buffer.sv
// Block-averages CORDIC x/y samples over 2^AVG_LOG2 valid cycles and queues
// the results in a first-word-fall-through FIFO with a sticky overflow flag.
module cordic_avg_buffer #(
    parameter int unsigned XY_BITS    = 12,
    parameter int unsigned AVG_LOG2   = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              RST,
    input  logic                              clear,
    input  logic                              valid_in,
    input  logic signed [XY_BITS-1:0]         x_i,
    input  logic signed [XY_BITS-1:0]         y_i,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic signed [XY_BITS-1:0]         x_avg,
    output logic signed [XY_BITS-1:0]         y_avg,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
    output logic                              overflow
);

    localparam int unsigned ACC_W = XY_BITS + AVG_LOG2;
    localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    logic signed [ACC_W-1:0]   acc_x, acc_y;
    logic signed [ACC_W-1:0]   sum_x, sum_y;
    logic signed [XY_BITS-1:0] res_x, res_y;
    logic [CNT_W-1:0]          cnt;
    logic [PTR_W-1:0]          wr_ptr, rd_ptr;
    logic signed [XY_BITS-1:0] mem_x [FIFO_DEPTH];
    logic signed [XY_BITS-1:0] mem_y [FIFO_DEPTH];
    logic                      last, pop, full, push, drop;

    // Accumulator wide enough for a full group, so the sum never wraps
    always_comb begin
        sum_x = acc_x + ACC_W'(x_i);
        sum_y = acc_y + ACC_W'(y_i);
        res_x = XY_BITS'(sum_x >>> AVG_LOG2);
        res_y = XY_BITS'(sum_y >>> AVG_LOG2);
        last  = valid_in && (cnt == CNT_LAST);
        out_valid = (fifo_level != '0);
        pop   = out_valid && out_ready;
        full  = (fifo_level == LVL_FULL);
        push  = last && (!full || pop);
        drop  = last && full && !pop;
        x_avg = out_valid ? mem_x[rd_ptr] : '0;
        y_avg = out_valid ? mem_y[rd_ptr] : '0;
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            acc_x <= '0;
            acc_y <= '0;
            cnt   <= '0;
        end else if (clear) begin
            acc_x <= '0;
            acc_y <= '0;
            cnt   <= '0;
        end else if (valid_in) begin
            if (last) begin
                acc_x <= '0;
                acc_y <= '0;
                cnt   <= '0;
            end else begin
                acc_x <= sum_x;
                acc_y <= sum_y;
                cnt   <= cnt + CNT_W'(1);
            end
        end
    end

    // FIFO control; clear overrides both push and pop
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      fifo_level <= fifo_level + LVL_W'(1);
            else if (pop && !push) fifo_level <= fifo_level - LVL_W'(1);
            if (drop) overflow <= 1'b1;
        end
    end

    // Storage needs no reset: reads are masked by out_valid
    always_ff @(posedge clk) begin
        if (!clear && push) begin
            mem_x[wr_ptr] <= res_x;
            mem_y[wr_ptr] <= res_y;
        end
    end

endmodule
